// File: rtl/prog_truth_table_pkg.sv
// Shared types and constants for the programmable truth-table block.
package prog_truth_table_pkg;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_LOAD = 1'b1
  } ld_state_e;

  // Table contents after reset; bit k is the function value for input value k.
  localparam logic [63:0] PTT_RESET_TBL = 64'hD1;

  function automatic int ptt_depth(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/prog_truth_table_if.sv
// Configuration, evaluation and hit-counter signals of prog_truth_table.
interface prog_truth_table_if #(
  parameter int N_IN  = 3,
  parameter int CNT_W = 8
);

  logic             cfg_start;
  logic             cfg_valid;
  logic             cfg_bit;
  logic             cfg_busy;
  logic             cfg_done;
  logic             in_valid;
  logic [N_IN-1:0]  in_sel;
  logic             out_valid;
  logic             f;
  logic             hit_clr;
  logic [CNT_W-1:0] hit_count;

  modport master (
    output cfg_start, cfg_valid, cfg_bit, in_valid, in_sel, hit_clr,
    input  cfg_busy, cfg_done, out_valid, f, hit_count
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit, in_valid, in_sel, hit_clr,
    output cfg_busy, cfg_done, out_valid, f, hit_count
  );

endinterface

// File: rtl/ptt_cfg_loader.sv
// Serial table loader: collects 2**N_IN bits LSB first into a shadow register
// and raises commit on the cycle the last bit arrives, with the full word on tbl.
module ptt_cfg_loader
  import prog_truth_table_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_start,
  input  logic                          cfg_valid,
  input  logic                          cfg_bit,
  output logic                          busy,
  output logic                          commit,
  output logic [ptt_depth(N_IN)-1:0]    tbl
);

  localparam int              DEPTH    = ptt_depth(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(DEPTH - 1);

  ld_state_e        state_q, state_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [DEPTH-1:0] shadow_q, shadow_d;

  logic wr_load;
  logic last_bit;

  // A start always wins over a data bit in the same cycle.
  assign wr_load  = !cfg_start && (state_q == LD_LOAD) && cfg_valid;
  assign last_bit = wr_load && (idx_q == LAST_IDX);

  // NOTE: reset is synchronous and active-high; it lives inside the clocked
  // block so the whole block resets on a clock edge like any other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LD_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d = state_q;
    if (cfg_start) begin
      state_d = LD_LOAD;
    end else if (last_bit) begin
      state_d = LD_IDLE;
    end
  end

  always_comb begin
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (cfg_start) begin
      shadow_d = '0;
      idx_d    = '0;
      if (cfg_valid) begin
        shadow_d[0] = cfg_bit;
        idx_d       = N_IN'(1);
      end
    end else if (wr_load) begin
      shadow_d[idx_q] = cfg_bit;
      idx_d           = last_bit ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    busy   = (state_q == LD_LOAD);
    commit = last_bit;
    tbl    = shadow_d;
  end

endmodule

// File: rtl/prog_truth_table.sv
// Runtime-loadable N-input Boolean function: active table, registered lookup
// with valid strobe, and a saturating count of true results.
module prog_truth_table
  import prog_truth_table_pkg::*;
#(
  parameter int          N_IN        = 3,
  parameter logic [63:0] DEFAULT_TBL = PTT_RESET_TBL,
  parameter int          CNT_W       = 8
) (
  input logic          clk,
  input logic          rst,
  prog_truth_table_if.slave bus
);

  localparam int DEPTH = ptt_depth(N_IN);

  logic             ld_busy;
  logic             ld_commit;
  logic [DEPTH-1:0] ld_tbl;

  logic [DEPTH-1:0] active_q, active_d;
  logic             out_valid_q, out_valid_d;
  logic             f_q, f_d;
  logic             cfg_done_q, cfg_done_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic             lookup;

  ptt_cfg_loader #(
    .N_IN (N_IN)
  ) u_loader (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (bus.cfg_start),
    .cfg_valid (bus.cfg_valid),
    .cfg_bit   (bus.cfg_bit),
    .busy      (ld_busy),
    .commit    (ld_commit),
    .tbl       (ld_tbl)
  );

  // The lookup reads the pre-commit table, so an evaluation in the commit
  // cycle still sees the old function and a partial table is never used.
  assign lookup = active_q[bus.in_sel];

  always_comb begin
    active_d    = ld_commit ? ld_tbl : active_q;
    cfg_done_d  = ld_commit;
    out_valid_d = bus.in_valid;
    f_d         = bus.in_valid ? lookup : f_q;
  end

  // Counting at the edge that produces the result keeps hit_count in step
  // with out_valid/f; clear wins over a simultaneous true result.
  always_comb begin
    hit_d = hit_q;
    if (bus.hit_clr) begin
      hit_d = '0;
    end else if (bus.in_valid && lookup && (hit_q != '1)) begin
      hit_d = hit_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q    <= DEFAULT_TBL[DEPTH-1:0];
      cfg_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      f_q         <= 1'b0;
      hit_q       <= '0;
    end else begin
      active_q    <= active_d;
      cfg_done_q  <= cfg_done_d;
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      hit_q       <= hit_d;
    end
  end

  assign bus.cfg_busy  = ld_busy;
  assign bus.cfg_done  = cfg_done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.f         = f_q;
  assign bus.hit_count = hit_q;

endmodule
